// File: rtl/hist_eq_pkg.sv
// rtl/hist_eq_pkg.sv - shared phase/sub-state types, constants and saturating increment
package hist_eq_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_CLR  = 3'd1,
    PH_SCAN = 3'd2,
    PH_CDF  = 3'd3,
    PH_MAP  = 3'd4,
    PH_DONE = 3'd5
  } phase_t;

  typedef enum logic [2:0] {S_RD, S_CAP, S_WB, S_HRD, S_HWR} sub_t;

  localparam int NBINS         = 256;
  localparam int SCAN_WORD_CYC = 34;
  localparam int MAP_WORD_CYC  = 35;

  // Bins stick at their all-ones value instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] vmax;
    vmax = (32'd1 << w) - 32'd1;
    return (v == vmax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hist_lut.sv
// rtl/hist_lut.sv - remap LUT: one sync write port, LANES combinational read ports
module hist_lut
  import hist_eq_pkg::*;
#(
  parameter int LANES = 16,
  parameter int PIXW  = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PIXW-1:0]        waddr,
  input  logic [PIXW-1:0]        wdata,
  input  logic [LANES*PIXW-1:0]  raddr,
  output logic [LANES*PIXW-1:0]  rdata
);

  logic [PIXW-1:0] mem [NBINS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      rdata[i*PIXW +: PIXW] = mem[raddr[i*PIXW +: PIXW]];
    end
  end

endmodule

// File: rtl/hist_eq_ctrl.sv
// rtl/hist_eq_ctrl.sv - histogram-equalization sequencer: clear, scan, CDF/LUT build, remap
module hist_eq_ctrl
  import hist_eq_pkg::*;
#(
  parameter int NWORDS    = 8192,
  parameter int LANES     = 16,
  parameter int PIXW      = 8,
  parameter int BINW      = 16,
  parameter int LOG2_NPIX = 17,
  localparam int AW       = $clog2(NWORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [AW-1:0]         img_addr,
  output logic                  img_rd,
  input  logic [LANES*PIXW-1:0] img_rdata,
  output logic                  img_we,
  output logic [LANES*PIXW-1:0] img_wdata,
  output logic                  h_sel,
  output logic [PIXW-1:0]       h_addr,
  output logic                  h_rd,
  input  logic [BINW-1:0]       h_rdata,
  output logic                  h_we,
  output logic [BINW-1:0]       h_wdata,
  output logic                  busy,
  output logic                  finish,
  output logic [2:0]            phase
);

  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CDFW = LOG2_NPIX + 1;
  localparam int WW   = LANES * PIXW;
  localparam int PW   = CDFW + PIXW;

  phase_t          ph_q, ph_d;
  sub_t            sub_q, sub_d;
  logic [AW-1:0]   w_q, w_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [PIXW:0]   bin_q, bin_d;
  logic [CDFW-1:0] cdf_q, cdf_d, cdf_sum;
  logic [WW-1:0]   word_q, word_d;

  logic            lut_we;
  logic [PIXW-1:0] lut_wdata;
  logic [WW-1:0]   lut_rdata;
  logic [PIXW-1:0] pix;
  logic [PW-1:0]   prod, scaled;

  hist_lut #(.LANES(LANES), .PIXW(PIXW)) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (bin_q[PIXW-1:0]),
    .wdata (lut_wdata),
    .raddr (img_rdata),
    .rdata (lut_rdata)
  );

  // word_q holds raw pixels in SCAN and remapped pixels in MAP, so one lane mux serves both.
  assign pix     = word_q[lane_q*PIXW +: PIXW];
  assign cdf_sum = cdf_q + CDFW'(h_rdata);

  always_comb begin
    prod      = {{PIXW{1'b0}}, cdf_sum} * PW'(NBINS - 1);
    scaled    = prod >> LOG2_NPIX;
    lut_wdata = (scaled > PW'(NBINS - 1)) ? PIXW'(NBINS - 1) : scaled[PIXW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q   <= PH_IDLE;
      sub_q  <= S_RD;
      w_q    <= '0;
      lane_q <= '0;
      bin_q  <= '0;
      cdf_q  <= '0;
      word_q <= '0;
    end else begin
      ph_q   <= ph_d;
      sub_q  <= sub_d;
      w_q    <= w_d;
      lane_q <= lane_d;
      bin_q  <= bin_d;
      cdf_q  <= cdf_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    ph_d      = ph_q;
    sub_d     = sub_q;
    w_d       = w_q;
    lane_d    = lane_q;
    bin_d     = bin_q;
    cdf_d     = cdf_q;
    word_d    = word_q;
    img_addr  = '0;
    img_rd    = 1'b0;
    img_we    = 1'b0;
    img_wdata = '0;
    h_sel     = 1'b0;
    h_addr    = '0;
    h_rd      = 1'b0;
    h_we      = 1'b0;
    h_wdata   = '0;
    lut_we    = 1'b0;

    case (ph_q)
      PH_IDLE, PH_DONE: begin
        if (start) begin
          ph_d   = PH_CLR;
          sub_d  = S_RD;
          w_d    = '0;
          lane_d = '0;
          bin_d  = '0;
        end
      end

      // bin_q[PIXW] walks bank 0 then bank 1.
      PH_CLR: begin
        h_we   = 1'b1;
        h_sel  = bin_q[PIXW];
        h_addr = bin_q[PIXW-1:0];
        bin_d  = bin_q + 1'b1;
        if (bin_q == {(PIXW+1){1'b1}}) begin
          ph_d  = PH_SCAN;
          sub_d = S_RD;
        end
      end

      PH_SCAN, PH_MAP: begin
        case (sub_q)
          S_RD: begin
            img_rd   = 1'b1;
            img_addr = w_q;
            sub_d    = S_CAP;
          end
          S_CAP: begin
            lane_d = '0;
            if (ph_q == PH_SCAN) begin
              word_d = img_rdata;
              sub_d  = S_HRD;
            end else begin
              word_d = lut_rdata;
              sub_d  = S_WB;
            end
          end
          S_WB: begin
            img_we    = 1'b1;
            img_addr  = w_q;
            img_wdata = word_q;
            sub_d     = S_HRD;
          end
          S_HRD: begin
            h_rd   = 1'b1;
            h_sel  = (ph_q == PH_MAP);
            h_addr = pix;
            sub_d  = S_HWR;
          end
          S_HWR: begin
            h_we    = 1'b1;
            h_sel   = (ph_q == PH_MAP);
            h_addr  = pix;
            h_wdata = BINW'(sat_inc(32'(h_rdata), BINW));
            if (lane_q == LW'(LANES - 1)) begin
              lane_d = '0;
              sub_d  = S_RD;
              if (w_q == AW'(NWORDS - 1)) begin
                w_d   = '0;
                bin_d = '0;
                cdf_d = '0;
                if (ph_q == PH_SCAN) begin
                  ph_d  = PH_CDF;
                  sub_d = S_HRD;
                end else begin
                  ph_d = PH_DONE;
                end
              end else begin
                w_d = w_q + 1'b1;
              end
            end else begin
              lane_d = lane_q + 1'b1;
              sub_d  = S_HRD;
            end
          end
          default: sub_d = S_RD;
        endcase
      end

      PH_CDF: begin
        case (sub_q)
          S_HRD: begin
            h_rd   = 1'b1;
            h_addr = bin_q[PIXW-1:0];
            sub_d  = S_HWR;
          end
          S_HWR: begin
            cdf_d  = cdf_sum;
            lut_we = 1'b1;
            if (bin_q[PIXW-1:0] == {PIXW{1'b1}}) begin
              ph_d  = PH_MAP;
              sub_d = S_RD;
              w_d   = '0;
              bin_d = '0;
            end else begin
              bin_d = bin_q + 1'b1;
              sub_d = S_HRD;
            end
          end
          default: sub_d = S_HRD;
        endcase
      end

      default: ph_d = PH_IDLE;
    endcase
  end

  assign busy   = (ph_q == PH_CLR) || (ph_q == PH_SCAN) || (ph_q == PH_CDF) || (ph_q == PH_MAP);
  assign finish = (ph_q == PH_DONE);
  assign phase  = ph_q;

endmodule

// File: tb/tb_hist_eq_ctrl.sv
// tb/tb_hist_eq_ctrl.sv - directed self-checking bench for hist_eq_ctrl
module tb_hist_eq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   viol   = 0;

  // instance A: 4 words, 64 pixels, 16-bit bins
  logic         a_start;
  logic [1:0]   a_img_addr;
  logic         a_img_rd, a_img_we;
  logic [127:0] a_img_rdata, a_img_wdata;
  logic         a_h_sel, a_h_rd, a_h_we;
  logic [7:0]   a_h_addr;
  logic [15:0]  a_h_rdata, a_h_wdata;
  logic         a_busy, a_finish;
  logic [2:0]   a_phase;
  logic [127:0] a_img [4];
  logic [15:0]  a_hist [2][256];
  logic         a_ld;
  logic [1:0]   a_ld_addr;
  logic [127:0] a_ld_data;

  // instance B: 32 words, 512 pixels, 4-bit bins so saturation is reachable
  logic         b_start;
  logic [4:0]   b_img_addr;
  logic         b_img_rd, b_img_we;
  logic [127:0] b_img_rdata, b_img_wdata;
  logic         b_h_sel, b_h_rd, b_h_we;
  logic [7:0]   b_h_addr;
  logic [3:0]   b_h_rdata, b_h_wdata;
  logic         b_busy, b_finish;
  logic [2:0]   b_phase;
  logic [127:0] b_img [32];
  logic [3:0]   b_hist [2][256];
  logic         b_ld;
  logic [4:0]   b_ld_addr;
  logic [127:0] b_ld_data;

  hist_eq_ctrl #(.NWORDS(4), .LANES(16), .PIXW(8), .BINW(16), .LOG2_NPIX(6)) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start),
    .img_addr(a_img_addr), .img_rd(a_img_rd), .img_rdata(a_img_rdata),
    .img_we(a_img_we), .img_wdata(a_img_wdata),
    .h_sel(a_h_sel), .h_addr(a_h_addr), .h_rd(a_h_rd), .h_rdata(a_h_rdata),
    .h_we(a_h_we), .h_wdata(a_h_wdata),
    .busy(a_busy), .finish(a_finish), .phase(a_phase)
  );

  hist_eq_ctrl #(.NWORDS(32), .LANES(16), .PIXW(8), .BINW(4), .LOG2_NPIX(9)) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start),
    .img_addr(b_img_addr), .img_rd(b_img_rd), .img_rdata(b_img_rdata),
    .img_we(b_img_we), .img_wdata(b_img_wdata),
    .h_sel(b_h_sel), .h_addr(b_h_addr), .h_rd(b_h_rd), .h_rdata(b_h_rdata),
    .h_we(b_h_we), .h_wdata(b_h_wdata),
    .busy(b_busy), .finish(b_finish), .phase(b_phase)
  );

  always @(posedge clk) begin
    if (a_img_rd) a_img_rdata <= a_img[a_img_addr];
    if (a_img_we) a_img[a_img_addr] <= a_img_wdata;
    else if (a_ld) a_img[a_ld_addr] <= a_ld_data;
    if (a_h_rd) a_h_rdata <= a_hist[a_h_sel][a_h_addr];
    if (a_h_we) a_hist[a_h_sel][a_h_addr] <= a_h_wdata;
  end

  always @(posedge clk) begin
    if (b_img_rd) b_img_rdata <= b_img[b_img_addr];
    if (b_img_we) b_img[b_img_addr] <= b_img_wdata;
    else if (b_ld) b_img[b_ld_addr] <= b_ld_data;
    if (b_h_rd) b_h_rdata <= b_hist[b_h_sel][b_h_addr];
    if (b_h_we) b_hist[b_h_sel][b_h_addr] <= b_h_wdata;
  end

  always @(negedge clk) begin
    viol <= viol
      + (($countones({a_img_rd, a_img_we, a_h_rd, a_h_we}) > 1) ? 1 : 0)
      + (($countones({b_img_rd, b_img_we, b_h_rd, b_h_we}) > 1) ? 1 : 0)
      + ((!a_busy && (a_img_rd | a_img_we | a_h_rd | a_h_we)) ? 1 : 0)
      + ((!b_busy && (b_img_rd | b_img_we | b_h_rd | b_h_we)) ? 1 : 0);
  end

  task automatic a_load(input logic [127:0] w0, input logic [127:0] rest);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_ld      = 1'b1;
      a_ld_addr = 2'(i);
      a_ld_data = (i == 0) ? w0 : rest;
    end
    @(negedge clk);
    a_ld = 1'b0;
  endtask

  task automatic b_load(input bit ramp);
    logic [127:0] d;
    for (int i = 0; i < 32; i++) begin
      for (int l = 0; l < 16; l++) d[l*8 +: 8] = ramp ? 8'((16 * i + l) % 256) : 8'h10;
      @(negedge clk);
      b_ld      = 1'b1;
      b_ld_addr = 5'(i);
      b_ld_data = d;
    end
    @(negedge clk);
    b_ld = 1'b0;
  endtask

  // cycles = index, from the first CLR cycle, of the cycle in which finish is first seen
  task automatic a_run(input int spur, input bit zchk, output int cycles);
    int nz;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    cycles  = 0;
    checks++;
    if (a_phase !== 3'd1 || a_finish !== 1'b0)
      begin errors++; $display("FAIL start_to_clr: phase=%0d finish=%0b expected 1/0", a_phase, a_finish); end
    while (!a_finish && cycles < 5000) begin
      if (cycles == spur) a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      cycles++;
      if (cycles == spur + 1) begin
        checks++;
        if (a_phase !== 3'd2)
          begin errors++; $display("FAIL spur_start_scan: phase=%0d expected 2", a_phase); end
      end
      if (zchk && cycles == 512) begin
        nz = 0;
        for (int s = 0; s < 2; s++)
          for (int b = 0; b < 256; b++) if (a_hist[s][b] !== 16'd0) nz++;
        checks++;
        if (nz !== 0) begin errors++; $display("FAIL clr_banks: nonzero bins=%0d expected 0", nz); end
      end
    end
    checks++;
    if (!a_finish) begin errors++; $display("FAIL a_timeout: finish=%0b expected 1", a_finish); end
  endtask

  task automatic b_run(output int cycles);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cycles  = 0;
    while (!b_finish && cycles < 10000) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!b_finish) begin errors++; $display("FAIL b_timeout: finish=%0b expected 1", b_finish); end
  endtask

  task automatic a_verify_zero_run(input string tag, input int cycles);
    int nz, bad;
    logic [127:0] ff_word;
    ff_word = {16{8'hFF}};
    checks++;
    if (cycles !== 1300) begin errors++; $display("FAIL %s_cycles: got %0d expected 1300", tag, cycles); end
    checks++;
    if (a_hist[0][0] !== 16'd64) begin errors++; $display("FAIL %s_orig0: got %0d expected 64", tag, a_hist[0][0]); end
    nz = 0;
    for (int b = 1; b < 256; b++) if (a_hist[0][b] !== 16'd0) nz++;
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL %s_orig_rest: nonzero=%0d expected 0", tag, nz); end
    bad = 0;
    for (int w = 0; w < 4; w++) if (a_img[w] !== ff_word) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_image: bad words=%0d expected 0", tag, bad); end
    checks++;
    if (a_hist[1][255] !== 16'd64) begin errors++; $display("FAIL %s_eq255: got %0d expected 64", tag, a_hist[1][255]); end
    nz = 0;
    for (int b = 0; b < 255; b++) if (a_hist[1][b] !== 16'd0) nz++;
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL %s_eq_rest: nonzero=%0d expected 0", tag, nz); end
    checks++;
    if (a_phase !== 3'd5 || a_busy !== 1'b0 || a_finish !== 1'b1)
      begin errors++; $display("FAIL %s_done: phase=%0d busy=%0b finish=%0b expected 5/0/1", tag, a_phase, a_busy, a_finish); end
  endtask

  task automatic test_reset();
    checks++;
    if ({a_img_addr, a_img_rd, a_img_we, a_img_wdata, a_h_sel, a_h_addr, a_h_rd, a_h_we, a_h_wdata, a_busy, a_finish, a_phase} !== '0)
      begin errors++; $display("FAIL reset_a_outputs: phase=%0d busy=%0b finish=%0b expected all 0", a_phase, a_busy, a_finish); end
    checks++;
    if ({b_img_rd, b_img_we, b_h_rd, b_h_we, b_busy, b_finish, b_phase} !== '0)
      begin errors++; $display("FAIL reset_b_outputs: phase=%0d busy=%0b expected all 0", b_phase, b_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_phase !== 3'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL idle_hold: phase=%0d expected 0", a_phase); end
  endtask

  task automatic test_all_zero();
    int cyc;
    a_load('0, '0);
    a_run(-1, 1'b0, cyc);
    a_verify_zero_run("zero", cyc);
  endtask

  task automatic test_rmw_serial();
    int cyc;
    logic [127:0] ff_word, bf_word;
    ff_word = {16{8'hFF}};
    bf_word = {16{8'hBF}};
    a_load({16{8'hAB}}, '0);
    a_run(-1, 1'b0, cyc);
    checks++;
    if (a_hist[0][8'hAB] !== 16'd16) begin errors++; $display("FAIL rmw_origAB: got %0d expected 16", a_hist[0][8'hAB]); end
    checks++;
    if (a_hist[0][0] !== 16'd48) begin errors++; $display("FAIL rmw_orig0: got %0d expected 48", a_hist[0][0]); end
    checks++;
    if (a_img[0] !== ff_word || a_img[1] !== bf_word || a_img[3] !== bf_word)
      begin errors++; $display("FAIL rmw_image: w0=%h w1=%h expected %h %h", a_img[0], a_img[1], ff_word, bf_word); end
    checks++;
    if (a_hist[1][8'hFF] !== 16'd16 || a_hist[1][8'hBF] !== 16'd48)
      begin errors++; $display("FAIL rmw_eq: eqFF=%0d eqBF=%0d expected 16 48", a_hist[1][8'hFF], a_hist[1][8'hBF]); end
  endtask

  task automatic test_start_handling();
    int cyc;
    a_load('0, '0);
    a_run(600, 1'b1, cyc);
    a_verify_zero_run("restart", cyc);
  endtask

  task automatic test_reset_mid_map();
    int cyc;
    a_load('0, '0);
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (1199) @(negedge clk);
    checks++;
    if (a_phase !== 3'd4) begin errors++; $display("FAIL pre_reset_map: phase=%0d expected 4", a_phase); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_img_addr, a_img_rd, a_img_we, a_img_wdata, a_h_sel, a_h_addr, a_h_rd, a_h_we, a_h_wdata, a_busy, a_finish, a_phase} !== '0)
      begin errors++; $display("FAIL async_reset: phase=%0d busy=%0b img_we=%0b h_we=%0b expected all 0", a_phase, a_busy, a_img_we, a_h_we); end
    @(negedge clk);
    rst_n = 1'b1;
    a_load('0, '0);
    a_run(-1, 1'b0, cyc);
    a_verify_zero_run("after_reset", cyc);
  endtask

  task automatic test_ramp();
    int cyc, bad;
    int exp_eq [256];
    logic [127:0] wv;
    logic [7:0] lut_v;
    b_load(1'b1);
    b_run(cyc);
    checks++;
    if (cyc !== 3232) begin errors++; $display("FAIL ramp_cycles: got %0d expected 3232", cyc); end
    bad = 0;
    for (int b = 0; b < 256; b++) if (b_hist[0][b] !== 4'd2) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ramp_orig: bins not 2=%0d expected 0", bad); end
    for (int b = 0; b < 256; b++) exp_eq[b] = 0;
    bad = 0;
    for (int w = 0; w < 32; w++) begin
      wv = b_img[w];
      for (int l = 0; l < 16; l++) begin
        lut_v = 8'((((16 * w + l) % 256 + 1) * 255) >> 8);
        if (wv[l*8 +: 8] !== lut_v) bad++;
        if (exp_eq[lut_v] < 15) exp_eq[lut_v]++;
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ramp_image: bad pixels=%0d expected 0", bad); end
    wv = b_img[7];
    checks++;
    if (b_img[0][7:0] !== 8'd0 || wv[127:120] !== 8'd127)
      begin errors++; $display("FAIL ramp_lut_lo: lut0=%0d lut127=%0d expected 0 127", b_img[0][7:0], wv[127:120]); end
    wv = b_img[15];
    checks++;
    if (wv[127:120] !== 8'd255) begin errors++; $display("FAIL ramp_lut255: got %0d expected 255", wv[127:120]); end
    bad = 0;
    for (int b = 0; b < 256; b++) if (b_hist[1][b] !== 4'(exp_eq[b])) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ramp_eq: bad bins=%0d expected 0", bad); end
  endtask

  task automatic test_saturate();
    int cyc, nz, bad;
    logic [127:0] w7;
    w7 = {16{8'h07}};
    b_load(1'b0);
    b_run(cyc);
    checks++;
    if (cyc !== 3232) begin errors++; $display("FAIL sat_cycles: got %0d expected 3232", cyc); end
    checks++;
    if (b_hist[0][8'h10] !== 4'hF) begin errors++; $display("FAIL sat_orig10: got %0d expected 15", b_hist[0][8'h10]); end
    nz = 0;
    for (int b = 0; b < 256; b++) if (b != 16 && b_hist[0][b] !== 4'd0) nz++;
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL sat_orig_rest: nonzero=%0d expected 0", nz); end
    bad = 0;
    for (int w = 0; w < 32; w++) if (b_img[w] !== w7) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sat_image: bad words=%0d expected 0", bad); end
    checks++;
    if (b_hist[1][7] !== 4'hF) begin errors++; $display("FAIL sat_eq7: got %0d expected 15", b_hist[1][7]); end
  endtask

  task automatic test_strobes();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_rules: violations=%0d expected 0", viol); end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_ld    = 1'b0;
    b_ld    = 1'b0;
    a_ld_addr = '0;
    a_ld_data = '0;
    b_ld_addr = '0;
    b_ld_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_all_zero();
    test_rmw_serial();
    test_start_handling();
    test_reset_mid_map();
    test_ramp();
    test_saturate();
    test_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
